mem_access_unit: RTL and testbench

Sized data-memory access sequencer for the MIPS datapath. It sits in the MEM stage between the instruction decoder's 2-bit `MemRead`/`MemWrite` size codes and a word-wide data memory. It runs one word, halfword or byte transaction per request over a req/ack handshake, using read-modify-write for sub-word stores. It stalls the pipeline until the transaction finishes.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared size codes, sequencer state encoding and alignment helper for the
// MEM-stage access unit.
package mem_pkg;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_WORD = 2'd1;
  localparam logic [1:0] MEM_BYTE = 2'd2;
  localparam logic [1:0] MEM_HALF = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_WORD: return (off == 2'b00);
      MEM_HALF: return !off[0];
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: sign-extending load extract and sub-word store merge.
// Purely combinational; off_i is the byte offset within the word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [15:0] st_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  sh;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign sh        = {off_i, 3'b000};
  assign byte_lane = rd_word_i[sh +: 8];
  assign half_lane = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

  always_comb begin
    ld_data_o = rd_word_i;
    st_word_o = rd_word_i;
    case (size_i)
      MEM_BYTE: begin
        ld_data_o = {{24{byte_lane[7]}}, byte_lane};
        st_word_o[sh +: 8] = st_data_i[7:0];
      end
      MEM_HALF: begin
        ld_data_o = {{16{half_lane[15]}}, half_lane};
        if (off_i[1]) st_word_o[31:16] = st_data_i;
        else          st_word_o[15:0]  = st_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: one word/half/byte access per request over req/ack,
// read-modify-write for sub-word stores, stalling the pipeline until done.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Done,
  output logic              AlignErr,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData
);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              done_q, align_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        size_q, off_q;
  logic [15:0]       st_data_q;

  logic              is_store, req_present, aligned, accept;
  logic              beat_state, beat_ack;
  logic [1:0]        req_size;
  logic [31:0]       ld_data, st_word;

  // A store and a load in the same cycle: the store wins.
  assign is_store    = (MemWrite != MEM_NONE);
  assign req_size    = is_store ? MemWrite : MemRead;
  assign req_present = is_store || (MemRead != MEM_NONE);
  assign aligned     = size_aligned(req_size, Address[1:0]);
  assign accept      = (state_q == ST_IDLE) && req_present;

  assign beat_state = state_q inside {ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR};
  assign beat_ack   = req_q && MemAck;

  mem_lane_align u_lane (
    .rd_word_i (MemRData),
    .st_data_i (st_data_q),
    .size_i    (size_q),
    .off_i     (off_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d = state_q;
    // Request is raised the cycle after entering a beat state, dropped on ack.
    req_d   = beat_state && !beat_ack;
    we_d    = ((state_q == ST_WR) || (state_q == ST_RMW_WR)) && !beat_ack;
    case (state_q)
      ST_IDLE: begin
        if (req_present) begin
          if (!aligned)                 state_d = ST_DONE;
          else if (!is_store)           state_d = ST_RD;
          else if (req_size == MEM_WORD) state_d = ST_WR;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_RD, ST_WR: if (beat_ack) state_d = ST_DONE;
      ST_RMW_RD:    if (beat_ack) state_d = ST_RMW_WR;
      ST_RMW_WR:    if (beat_ack) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      align_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      size_q      <= MEM_NONE;
      off_q       <= 2'b00;
      st_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      done_q      <= (state_d == ST_DONE);
      align_err_q <= accept && !aligned;
      if (accept) begin
        size_q    <= req_size;
        off_q     <= Address[1:0];
        st_data_q <= WriteData[15:0];
        addr_q    <= {Address[ADDR_W-1:2], 2'b00};
      end
      if (accept && is_store)
        wdata_q <= WriteData;
      if ((state_q == ST_RMW_RD) && beat_ack)
        wdata_q <= st_word;
      if ((state_q == ST_RD) && beat_ack)
        rdata_q <= ld_data;
    end
  end

  assign Stall    = accept || beat_state;
  assign Done     = done_q;
  assign AlignErr = align_err_q;
  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign ReadData = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: byte-array reference model vs a
// word-wide memory responder with random ack wait states.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic        Stall, Done, AlignErr, MemReq, MemWe, MemAck;
  logic [31:0] MemAddr, MemWData, MemRData;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem_w   [0:15];
  logic [7:0]  ref_mem [0:63];
  logic [31:0] exp_rdata;
  int          cur_wait;
  int          wait_cnt;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .AlignErr  (AlignErr),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemAck    (MemAck),
    .MemRData  (MemRData)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    beat_t b;
    b.we = we;
    b.addr = addr;
    b.wdata = wdata;
    return b;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[a + 32'(i)];
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    mem_w[idx] = v;
    for (int b = 0; b < 4; b++) ref_mem[4*idx + b] = v[8*b +: 8];
  endtask

  // Memory responder: acks on the falling edge so the DUT samples it on the next rising edge.
  initial begin
    MemAck = 1'b0;
    MemRData = '0;
    wait_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!MemReq) begin
        MemAck = 1'b0;
        wait_cnt = cur_wait;
        MemRData = $urandom;
      end else if (exp_q.size() == 0) begin
        check_eq("beat_unexpected", 32'(MemReq), 32'd0);
        MemAck = 1'b0;
      end else begin
        check_eq("beat_we", 32'(MemWe), 32'(exp_q[0].we));
        check_eq("beat_addr", MemAddr, exp_q[0].addr);
        if (exp_q[0].we) check_eq("beat_wdata", MemWData, exp_q[0].wdata);
        if (wait_cnt > 0) begin
          wait_cnt--;
          MemAck = 1'b0;
          MemRData = $urandom;
        end else begin
          MemAck = 1'b1;
          if (MemWe) mem_w[MemAddr[5:2]] = MemWData;
          else       MemRData = mem_w[MemAddr[5:2]];
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic do_op(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] d, input int w);
    logic [1:0]  size;
    logic        store, ok, got;
    logic [31:0] v, wa;
    int          nb, exp_lat, n;
    store = (wr != 2'd0);
    size  = store ? wr : rd;
    nb    = (size == 2'd1) ? 4 : (size == 2'd2) ? 1 : 2;
    ok    = ((a % 32'(nb)) == 32'd0);
    wa    = a & ~32'd3;
    if (!ok) begin
      exp_lat = 1;
    end else if (!store) begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8*i));
      if (nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      exp_rdata = v;
      exp_q.push_back(mk_beat(1'b0, wa, 32'd0));
      exp_lat = 3 + w;
    end else begin
      if (nb < 4) exp_q.push_back(mk_beat(1'b0, wa, 32'd0));
      for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      exp_q.push_back(mk_beat(1'b1, wa, ref_word(wa)));
      exp_lat = (nb < 4) ? 5 + 2*w : 3 + w;
    end

    MemRead = rd; MemWrite = wr; Address = a; WriteData = d; cur_wait = w;
    #1;
    check_eq("stall_req", 32'(Stall), 32'd1);
    n = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(posedge Clk); #1;
      n++;
      MemRead = 2'd0;
      MemWrite = 2'd0;
      if (Done) got = 1'b1;
      else begin
        check_eq("stall_busy", 32'(Stall), 32'd1);
        check_eq("alignerr_early", 32'(AlignErr), 32'd0);
      end
    end
    check_eq("latency", 32'(n), 32'(exp_lat));
    if (got) begin
      check_eq("align_err", 32'(AlignErr), 32'(!ok));
      check_eq("stall_done", 32'(Stall), 32'd0);
      check_eq("read_data", ReadData, exp_rdata);
      check_eq("beats_left", 32'(exp_q.size()), 32'd0);
    end
    exp_q.delete();
    @(posedge Clk); #1;
    check_eq("done_pulse", 32'(Done), 32'd0);
    check_eq("align_pulse", 32'(AlignErr), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    MemRead = 2'd0; MemWrite = 2'd0; Address = '0; WriteData = '0;
    cur_wait = 0;
    exp_rdata = '0;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    #12;
    check_eq("rst_readdata", ReadData, 32'd0);
    check_eq("rst_memreq", 32'(MemReq), 32'd0);
    check_eq("rst_memwe", 32'(MemWe), 32'd0);
    check_eq("rst_memaddr", MemAddr, 32'd0);
    check_eq("rst_memwdata", MemWData, 32'd0);
    check_eq("rst_done", 32'(Done), 32'd0);
    check_eq("rst_alignerr", 32'(AlignErr), 32'd0);
    check_eq("rst_stall", 32'(Stall), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    poke(4, 32'h8899AABB);
    do_op(2'd1, 2'd0, 32'h10, 32'd0, 0);
    check_eq("lw_value", ReadData, 32'h8899AABB);
    poke(4, 32'h80112233);
    do_op(2'd2, 2'd0, 32'h13, 32'd0, 0);
    check_eq("lb_value", ReadData, 32'hFFFFFF80);
    do_op(2'd3, 2'd0, 32'h12, 32'd0, 1);
    check_eq("lh_value", ReadData, 32'hFFFF8011);
    poke(8, 32'h11223344);
    do_op(2'd0, 2'd2, 32'h21, 32'h000000CD, 0);
    check_eq("sb_mem", mem_w[8], 32'h1122CD44);
    do_op(2'd0, 2'd1, 32'h30, 32'hCAFEF00D, 4);
    check_eq("sw_mem", mem_w[12], 32'hCAFEF00D);
    do_op(2'd3, 2'd0, 32'h13, 32'd0, 0);
    do_op(2'd1, 2'd0, 32'h12, 32'd0, 0);
    check_eq("misalign_hold", ReadData, 32'hFFFF8011);

    // Reset while the RMW read beat is waiting for ack.
    poke(9, 32'hA5A5A5A5);
    MemWrite = 2'd3; Address = 32'h26; WriteData = 32'h0000BEEF; cur_wait = 20;
    exp_q.push_back(mk_beat(1'b0, 32'h24, 32'd0));
    repeat (3) begin
      @(posedge Clk); #1;
      MemWrite = 2'd0;
    end
    check_eq("rst_pre_req", 32'(MemReq), 32'd1);
    Reset = 1'b1;
    #1;
    check_eq("midrst_memreq", 32'(MemReq), 32'd0);
    check_eq("midrst_memwe", 32'(MemWe), 32'd0);
    check_eq("midrst_memaddr", MemAddr, 32'd0);
    check_eq("midrst_memwdata", MemWData, 32'd0);
    check_eq("midrst_readdata", ReadData, 32'd0);
    check_eq("midrst_stall", 32'(Stall), 32'd0);
    check_eq("midrst_done", 32'(Done), 32'd0);
    exp_q.delete();
    exp_rdata = '0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    cur_wait = 0;
    @(posedge Clk); #1;
    check_eq("postrst_done", 32'(Done), 32'd0);
    do_op(2'd1, 2'd0, 32'h10, 32'd0, 0);
    do_op(2'd1, 2'd1, 32'h08, 32'h13579BDF, 0);
    check_eq("rw_both_mem", mem_w[2], 32'h13579BDF);

    for (int k = 0; k < 200; k++) begin
      logic [1:0] rd, wr;
      rd = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      if (rd == 2'd0 && wr == 2'd0) rd = 2'd1;
      do_op(rd, wr, 32'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 16; i++) check_eq("final_mem", mem_w[i], ref_word(32'(4*i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
